// File: rtl/offset_programmer.sv
// Offset programmer: for one target thread, writes a run of PO entries (offset, increment)
// and then the DO register over the H-space write bus, one write per matching thread slot.
module offset_programmer #(
  parameter int WRITE_WORD_WIDTH   = 36,
  parameter int WRITE_ADDR_WIDTH   = 12,
  parameter int ADDR_WIDTH         = 10,
  parameter int PO_INCR_WIDTH      = 4,
  parameter int PO_ENTRY_COUNT     = 4,
  parameter int PO_ENTRY_WIDTH     = 5,
  parameter int PO_ADDR_BASE       = 0,
  parameter int DO_ADDR            = 0,
  parameter int THREAD_COUNT       = 8,
  parameter int THREAD_COUNT_WIDTH = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [THREAD_COUNT_WIDTH-1:0] cmd_thread,
  input  logic [PO_ENTRY_WIDTH-1:0]     cmd_entries,
  input  logic [ADDR_WIDTH-1:0]         cmd_base,
  input  logic [ADDR_WIDTH-1:0]         cmd_stride,
  input  logic [PO_INCR_WIDTH-1:0]      cmd_incr,
  input  logic [ADDR_WIDTH-1:0]         cmd_do,
  input  logic [THREAD_COUNT_WIDTH-1:0] current_thread,
  input  logic                          write_cancel,
  output logic                          write_valid,
  output logic [WRITE_ADDR_WIDTH-1:0]   write_addr,
  output logic [WRITE_WORD_WIDTH-1:0]   write_data,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, PO, DO} state_t;

  localparam logic [PO_ENTRY_WIDTH-1:0]   N_MAX   = PO_ENTRY_WIDTH'(PO_ENTRY_COUNT);
  localparam logic [WRITE_ADDR_WIDTH-1:0] PO_BASE = WRITE_ADDR_WIDTH'(PO_ADDR_BASE);
  localparam logic [WRITE_ADDR_WIDTH-1:0] DO_A    = WRITE_ADDR_WIDTH'(DO_ADDR);

  state_t                          state, state_nxt;
  logic [THREAD_COUNT_WIDTH-1:0]   thr;
  logic [PO_ENTRY_WIDTH-1:0]       n, idx, idx_inc, n_cmd;
  logic [ADDR_WIDTH-1:0]           off, stride, do_val;
  logic [PO_INCR_WIDTH-1:0]        incr;
  logic                            start, accept;

  assign n_cmd   = (cmd_entries > N_MAX) ? N_MAX : cmd_entries;
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    write_valid = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    start       = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          start     = 1'b1;
          state_nxt = (n_cmd != '0) ? PO : DO;
        end
      end
      PO: begin
        write_valid                                = (current_thread == thr);
        write_addr                                 = PO_BASE + WRITE_ADDR_WIDTH'(idx);
        write_data[ADDR_WIDTH-1:0]                 = off;
        write_data[ADDR_WIDTH +: PO_INCR_WIDTH]    = incr;
        accept                                     = write_valid & ~write_cancel;
        if (accept && idx_inc == n) state_nxt = DO;
      end
      DO: begin
        write_valid                = (current_thread == thr);
        write_addr                 = DO_A;
        write_data[ADDR_WIDTH-1:0] = do_val;
        accept                     = write_valid & ~write_cancel;
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // off is a running sum (base + idx*stride) so no multiplier is needed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thr    <= '0;
      n      <= '0;
      idx    <= '0;
      off    <= '0;
      stride <= '0;
      incr   <= '0;
      do_val <= '0;
      done   <= 1'b0;
    end else begin
      done <= accept && (state == DO);
      if (start) begin
        thr    <= cmd_thread;
        n      <= n_cmd;
        idx    <= '0;
        off    <= cmd_base;
        stride <= cmd_stride;
        incr   <= cmd_incr;
        do_val <= cmd_do;
      end else if (accept && state == PO) begin
        idx <= idx_inc;
        off <= off + stride;
      end
    end
  end

endmodule

// File: tb/tb_offset_programmer.sv
// Directed bench for offset_programmer: round-robin thread slots, cancel retry,
// wrap/clamp, zero entries, mid-operation reset and back-to-back commands.
module tb_offset_programmer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_thread = '0;
  logic [4:0]  cmd_entries = '0;
  logic [9:0]  cmd_base = '0, cmd_stride = '0, cmd_do = '0;
  logic [3:0]  cmd_incr = '0;
  logic [2:0]  current_thread = '0;
  logic        write_cancel = 1'b0;
  logic        write_valid;
  logic [11:0] write_addr;
  logic [35:0] write_data;
  logic        done;

  int tests = 0;
  int fails = 0;
  int waited;
  bit seen;

  offset_programmer dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_thread(cmd_thread),
    .cmd_entries(cmd_entries), .cmd_base(cmd_base), .cmd_stride(cmd_stride),
    .cmd_incr(cmd_incr), .cmd_do(cmd_do), .current_thread(current_thread),
    .write_cancel(write_cancel), .write_valid(write_valid), .write_addr(write_addr),
    .write_data(write_data), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs sampled at the falling edge.
  task automatic adv();
    @(posedge clock);
    #1 current_thread = current_thread + 3'd1;
    @(negedge clock);
  endtask

  task automatic wait_write(input string tag, input logic [2:0] thr, input logic [11:0] addr,
                            input logic [35:0] data, input logic cancel, output int w);
    w = 0;
    while (!write_valid && w < 20) begin
      adv();
      w++;
    end
    if (!write_valid) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({tag, "_thr"}, 64'(current_thread), 64'(thr));
    chk({tag, "_addr"}, 64'(write_addr), 64'(addr));
    chk({tag, "_data"}, 64'(write_data), 64'(data));
    write_cancel = cancel;
    adv();
    write_cancel = 1'b0;
  endtask

  task automatic send_cmd(input string tag, input logic [2:0] thr, input logic [4:0] ent,
                          input logic [9:0] base, input logic [9:0] stride,
                          input logic [3:0] incr, input logic [9:0] dov);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    cmd_thread = thr; cmd_entries = ent; cmd_base = base;
    cmd_stride = stride; cmd_incr = incr; cmd_do = dov;
    cmd_valid = 1'b1;
    adv();
    cmd_valid = 1'b0;
    chk({tag, "_busy"}, 64'(cmd_ready), 64'd0);
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done_hi"}, 64'(done), 64'd1);
    chk({tag, "_ready_hi"}, 64'(cmd_ready), 64'd1);
    adv();
    chk({tag, "_done_lo"}, 64'(done), 64'd0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wv", 64'(write_valid), 64'd0);
    chk("rst_addr", 64'(write_addr), 64'd0);
    chk("rst_data", 64'(write_data), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    adv();

    // basic: incr sits at bit 10 above the 10-bit offset, so incr 2 contributes 0x800
    send_cmd("basic", 3'd3, 5'd4, 10'h100, 10'h010, 4'd2, 10'h3F0);
    wait_write("basic_po0", 3'd3, 12'd0, 36'h900, 1'b0, waited);
    wait_write("basic_po1", 3'd3, 12'd1, 36'h910, 1'b0, waited);
    chk("basic_gap", 64'(waited + 1), 64'd8);
    wait_write("basic_po2", 3'd3, 12'd2, 36'h920, 1'b0, waited);
    wait_write("basic_po3", 3'd3, 12'd3, 36'h930, 1'b0, waited);
    wait_write("basic_do", 3'd3, 12'd0, 36'h3F0, 1'b0, waited);
    expect_done("basic");

    // cancel on the second PO write: same entry reissued one full rotation later
    send_cmd("cxl", 3'd3, 5'd4, 10'h100, 10'h010, 4'd2, 10'h3F0);
    wait_write("cxl_po0", 3'd3, 12'd0, 36'h900, 1'b0, waited);
    wait_write("cxl_po1a", 3'd3, 12'd1, 36'h910, 1'b1, waited);
    wait_write("cxl_po1b", 3'd3, 12'd1, 36'h910, 1'b0, waited);
    chk("cxl_gap", 64'(waited + 1), 64'd8);
    wait_write("cxl_po2", 3'd3, 12'd2, 36'h920, 1'b0, waited);
    wait_write("cxl_po3", 3'd3, 12'd3, 36'h930, 1'b0, waited);
    wait_write("cxl_do", 3'd3, 12'd0, 36'h3F0, 1'b0, waited);
    expect_done("cxl");

    // wrap modulo 1024 and clamp of 7 entries to 4
    send_cmd("wrap", 3'd5, 5'd7, 10'h3F8, 10'h010, 4'd1, 10'h2AA);
    wait_write("wrap_po0", 3'd5, 12'd0, 36'h7F8, 1'b0, waited);
    wait_write("wrap_po1", 3'd5, 12'd1, 36'h408, 1'b0, waited);
    wait_write("wrap_po2", 3'd5, 12'd2, 36'h418, 1'b0, waited);
    wait_write("wrap_po3", 3'd5, 12'd3, 36'h428, 1'b0, waited);
    wait_write("wrap_do", 3'd5, 12'd0, 36'h2AA, 1'b0, waited);
    expect_done("wrap");

    // zero entries, target thread is the one in the slot right after acceptance
    send_cmd("zero", current_thread + 3'd1, 5'd0, 10'h111, 10'h001, 4'd7, 10'h3F0);
    wait_write("zero_do", current_thread, 12'd0, 36'h3F0, 1'b0, waited);
    chk("zero_latency", 64'(waited), 64'd0);
    expect_done("zero");

    // reset after the second PO write
    send_cmd("rstm", 3'd3, 5'd4, 10'h100, 10'h010, 4'd2, 10'h3F0);
    wait_write("rstm_po0", 3'd3, 12'd0, 36'h900, 1'b0, waited);
    wait_write("rstm_po1", 3'd3, 12'd1, 36'h910, 1'b0, waited);
    while (current_thread != 3'd3) adv();
    chk("rstm_pre_wv", 64'(write_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstm_ready", 64'(cmd_ready), 64'd1);
    chk("rstm_wv", 64'(write_valid), 64'd0);
    chk("rstm_addr", 64'(write_addr), 64'd0);
    chk("rstm_data", 64'(write_data), 64'd0);
    chk("rstm_done", 64'(done), 64'd0);
    adv();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      adv();
      if (write_valid) seen = 1'b1;
    end
    chk("rstm_quiet", 64'(seen), 64'd0);
    send_cmd("rstm2", 3'd3, 5'd2, 10'h100, 10'h010, 4'd2, 10'h0AA);
    wait_write("rstm2_po0", 3'd3, 12'd0, 36'h900, 1'b0, waited);
    wait_write("rstm2_po1", 3'd3, 12'd1, 36'h910, 1'b0, waited);
    wait_write("rstm2_do", 3'd3, 12'd0, 36'h0AA, 1'b0, waited);
    expect_done("rstm2");

    // back-to-back: a command held while busy must not be taken until the done cycle
    send_cmd("b2b", 3'd2, 5'd1, 10'h040, 10'h000, 4'd3, 10'h077);
    cmd_thread = 3'd5; cmd_entries = 5'd2; cmd_base = 10'h200;
    cmd_stride = 10'h001; cmd_incr = 4'd9; cmd_do = 10'h099;
    cmd_valid = 1'b1;
    wait_write("b2b_po0", 3'd2, 12'd0, 36'hC40, 1'b0, waited);
    wait_write("b2b_do", 3'd2, 12'd0, 36'h077, 1'b0, waited);
    chk("b2b_done", 64'(done), 64'd1);
    cmd_thread = 3'd6; cmd_entries = 5'd1; cmd_base = 10'h055;
    cmd_stride = 10'h001; cmd_incr = 4'hF; cmd_do = 10'h123;
    adv();
    cmd_valid = 1'b0;
    chk("b2b_taken", 64'(cmd_ready), 64'd0);
    wait_write("b2b2_po0", 3'd6, 12'd0, 36'h3C55, 1'b0, waited);
    wait_write("b2b2_do", 3'd6, 12'd0, 36'h123, 1'b0, waited);
    expect_done("b2b2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
